antirrebote_repeticion: RTL and testbench

Button conditioning stage that sits directly upstream of the N-bit display counter. It takes a raw, bouncing, active-low push button (KEY) and produces a clean debounced level plus single-cycle step pulses on CLOCK_50. Each press yields one pulse. Holding the button yields auto-repeat pulses after a hold delay. The counter consumes `pulse` as its increment enable, so one press advances it exactly once instead of free-running while the key is held.

---
 rtl/antirrebote_repeticion.sv | 158 +++++++++++++++
 tb/tb_antirrebote_repeticion.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/antirrebote_repeticion.sv
// Purpose : debounce a bouncing active-low push button and emit step pulses with auto-repeat.
// Latency : press/release seen DEBOUNCE_CYCLES+2 cycles after a clean key_n edge; outputs registered.
// Backpr. : none; pulse is a fire-and-forget one-cycle strobe, never high two cycles in a row.
//
// Ports:
//   CLOCK_50  in   sole clock, rising edge
//   reset     in   synchronous, active-high
//   key_n     in   raw button, active-low, asynchronous, bouncing
//   pressed   out  debounced level, active-high
//   pulse     out  one-cycle step strobe (first press, then auto-repeat while held)
//   repeating out  high while in auto-repeat
module antirrebote_repeticion #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 25_000_000,
  parameter int REPEAT_CYCLES   = 5_000_000
) (
  input  logic CLOCK_50,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic pulse,
  output logic repeating
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } state_t;

  // Synchronizer
  logic sync1_q, sync2_q;

  // Debouncer (db_n_q is the debounced level, active-low like the key)
  logic             db_n_q, db_n_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise, fall;

  // Pulse FSM
  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pulse_q, pulse_d;
  logic             rep_q, rep_d;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
    end
  end

  // The count only advances while the synchronized key disagrees with the
  // debounced level, so any one-cycle agreement restarts it from zero.
  // rise/fall are the flip events themselves; the FSM reacts to them on the
  // same edge the level register updates, keeping pulse aligned with pressed.
  always_comb begin
    db_n_d = db_n_q;
    cnt_d  = '0;
    rise   = 1'b0;
    fall   = 1'b0;
    if (sync2_q != db_n_q) begin
      if (cnt_q == CNT_LAST) begin
        db_n_d = sync2_q;
        rise   = ~sync2_q;
        fall   = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      db_n_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      db_n_q <= db_n_d;
      cnt_q  <= cnt_d;
    end
  end

  // Release takes priority over everything, including a timer expiry on the
  // same edge, so a release never produces a step.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pulse_d = 1'b0;
    rep_d   = rep_q;
    if (fall) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
      rep_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            pulse_d = 1'b1;
            tmr_d   = '0;
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_q == HOLD_LAST) begin
            pulse_d = 1'b1;
            tmr_d   = '0;
            state_d = ST_REPEAT;
            rep_d   = 1'b1;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_REPEAT: begin
          if (tmr_q == REP_LAST) begin
            pulse_d = 1'b1;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
          rep_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      pulse_q <= 1'b0;
      rep_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_d;
      rep_q   <= rep_d;
    end
  end

  assign pressed   = ~db_n_q;
  assign pulse     = pulse_q;
  assign repeating = rep_q;

endmodule

// File: tb/tb_antirrebote_repeticion.sv
module tb_antirrebote_repeticion;

  localparam int D = 4;
  localparam int H = 10;
  localparam int R = 3;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  logic key_n    = 1'b1;
  logic pressed, pulse, repeating;

  antirrebote_repeticion #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES    (H),
    .REPEAT_CYCLES  (R)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .key_n    (key_n),
    .pressed  (pressed),
    .pulse    (pulse),
    .repeating(repeating)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_err    = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at edge", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Rules: s at an edge is key_n sampled two edges earlier (1 right after reset).
  // The level flips once the last D samples since the previous flip all disagree
  // with it. While held, steps fall at press+0, press+H, press+H+k*R; release
  // (and reset) cancels everything.
  int edge_no   = 0;
  bit hist[$];
  bit svals[$];
  bit m_pressed = 1'b0;
  bit m_pulse   = 1'b0;
  bit m_rep     = 1'b0;
  int press_edge = 0;
  int mp[$];    // edges with a model pulse
  int mrise[$];
  int mfall[$];
  int mrep[$];

  always @(posedge CLOCK_50) begin
    bit s_used, flip, prev_rep;
    int d;
    edge_no++;
    prev_rep = m_rep;
    if (reset) begin
      hist = '{1'b1, 1'b1};
      svals.delete();
      m_pressed = 1'b0;
      m_pulse   = 1'b0;
      m_rep     = 1'b0;
    end else begin
      s_used = hist[hist.size()-2];
      hist.push_back(key_n);
      if (hist.size() > 4) void'(hist.pop_front());
      svals.push_back(s_used);
      if (svals.size() > D) void'(svals.pop_front());
      flip = (svals.size() == D);
      foreach (svals[k]) if (svals[k] == !m_pressed) flip = 1'b0;
      m_pulse = 1'b0;
      if (flip) begin
        m_pressed = !m_pressed;
        svals.delete();
        if (m_pressed) begin
          press_edge = edge_no;
          m_pulse    = 1'b1;
          mrise.push_back(edge_no);
        end else begin
          mfall.push_back(edge_no);
        end
      end else if (m_pressed) begin
        d = edge_no - press_edge;
        m_pulse = (d == H) || (d > H && ((d - H) % R) == 0);
      end
      m_rep = m_pressed && ((edge_no - press_edge) >= H);
      if (m_pulse) mp.push_back(edge_no);
      if (m_rep && !prev_rep) mrep.push_back(edge_no);
    end
  end

  // Compare process: outputs are meaningful after every edge.
  always @(negedge CLOCK_50) begin
    if (cmp_en) begin
      check("pressed",   32'(pressed),   32'(m_pressed));
      check("pulse",     32'(pulse),     32'(m_pulse));
      check("repeating", 32'(repeating), 32'(m_rep));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input int n);
    key_n = v;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic clear_logs();
    mp.delete(); mrise.delete(); mfall.delete(); mrep.delete();
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -100000;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int base, rst_edge;
    @(negedge CLOCK_50);
    cmp_en = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;

    // 1: idle after reset
    clear_logs();
    drive(1'b1, 20);
    check("t1_pulses", mp.size(), 0);
    check("t1_rises", mrise.size(), 0);

    // 2: long press with auto-repeat, then release
    clear_logs();
    base = edge_no + 1;
    drive(1'b0, 30);
    drive(1'b1, 20);
    check("t2_rise",    at(mrise, 0) - base, 5);
    check("t2_p0",      at(mp, 0) - base, 5);
    check("t2_p1",      at(mp, 1) - base, 15);
    check("t2_p2",      at(mp, 2) - base, 18);
    check("t2_p3",      at(mp, 3) - base, 21);
    check("t2_npulse",  mp.size(), 8);
    check("t2_rep",     at(mrep, 0) - base, 15);
    check("t2_fall",    at(mfall, 0) - base, 35);

    // 3: bounce then steady low
    clear_logs();
    drive(1'b0, 3); drive(1'b1, 1); drive(1'b0, 2); drive(1'b1, 1);
    base = edge_no + 1;
    drive(1'b0, 9);
    drive(1'b1, 15);
    check("t3_rise",   at(mrise, 0) - base, 5);
    check("t3_npulse", mp.size(), 1);

    // 4: short press, released well before the hold delay
    clear_logs();
    drive(1'b0, 8);
    drive(1'b1, 15);
    check("t4_npulse", mp.size(), 1);
    check("t4_rep",    mrep.size(), 0);

    // 5: reset during auto-repeat with the key still held
    clear_logs();
    drive(1'b0, 20);
    check("t5_rep_before", mrep.size(), 1);
    clear_logs();
    reset = 1'b1;
    rst_edge = edge_no + 1;
    @(negedge CLOCK_50);
    check("t5_pressed_rst", 32'(pressed), 0);
    check("t5_rep_rst",     32'(repeating), 0);
    reset = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    check("t5_p0", at(mp, 0) - rst_edge, 6);
    check("t5_p1", at(mp, 1) - rst_edge, 16);
    drive(1'b1, 15);

    // 6: release lands on a repeat expiry
    clear_logs();
    base = edge_no + 1;
    drive(1'b0, 16);
    drive(1'b1, 15);
    check("t6_fall",   at(mfall, 0) - base, 21);
    check("t6_npulse", mp.size(), 3);
    check("t6_last",   at(mp, 2) - base, 18);

    // random traffic
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge CLOCK_50);
        reset = 1'b0;
      end else if ($urandom_range(0, 1) == 0) begin
        drive(1'b0, $urandom_range(1, 40));
      end else begin
        drive(1'b1, $urandom_range(1, 12));
      end
    end
    drive(1'b1, 20);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
